// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode encodings, RX frame FSM states and the
// expected-parity helper also used by the TX parity generator.
package uart_pkg;

  typedef enum logic [2:0] {
    PAR_NONE  = 3'd0,
    PAR_EVEN  = 3'd1,
    PAR_ODD   = 3'd2,
    PAR_MARK  = 3'd3,
    PAR_SPACE = 3'd4
  } parity_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP   = 3'd3,
    ST_DONE   = 3'd4
  } rx_state_e;

  // Encodings 5..7 are reserved and behave as "no parity".
  function automatic parity_mode_e parity_mode_norm(input logic [2:0] mode);
    case (mode)
      3'd1:    return PAR_EVEN;
      3'd2:    return PAR_ODD;
      3'd3:    return PAR_MARK;
      3'd4:    return PAR_SPACE;
      default: return PAR_NONE;
    endcase
  endfunction

  // acc is the XOR of all data bits of the frame.
  function automatic logic parity_expected(input parity_mode_e mode, input logic acc);
    case (mode)
      PAR_EVEN: return acc;
      PAR_ODD:  return ~acc;
      PAR_MARK: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_sat_counter.sv
// Saturating event counter with synchronous clear; clear has priority over increment.
module uart_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_frame_check.sv
// UART RX frame checker: assembles LSB-first data bits, checks parity and stop
// bits, and emits one status pulse per completed frame plus error counters.
module uart_rx_frame_check
  import uart_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic [2:0]        parity_mode,
  input  logic              clear_cnt,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              parity_error,
  output logic              framing_error,
  output logic              busy,
  output logic [CNT_W-1:0]  parity_err_cnt,
  output logic [CNT_W-1:0]  framing_err_cnt
);

  // Handshake: frame_start and bit_valid are single-cycle strobes with no
  // back-pressure; rx_valid is a single-cycle pulse and its companions
  // (rx_data, parity_error, framing_error) hold until the next pulse.

  localparam logic [3:0] DATA_LAST = 4'(DATA_W - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

  rx_state_e         state;
  parity_mode_e      mode_q;
  logic [3:0]        bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_acc;
  logic              par_bit;
  logic              fe_q;

  logic stop_fe;
  logic par_exp;
  logic pe_inc;
  logic fe_inc;

  assign stop_fe = fe_q | ~bit_in;
  assign par_exp = parity_expected(mode_q, par_acc);
  assign busy    = (state != ST_IDLE);
  assign pe_inc  = (state == ST_DONE) && parity_error;
  assign fe_inc  = (state == ST_DONE) && framing_error;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      mode_q        <= PAR_NONE;
      bit_cnt       <= '0;
      shreg         <= '0;
      par_acc       <= 1'b0;
      par_bit       <= 1'b0;
      fe_q          <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      // A start strobe restarts from any state and swallows a coincident bit.
      if (frame_start) begin
        state   <= ST_DATA;
        mode_q  <= parity_mode_norm(parity_mode);
        bit_cnt <= '0;
        par_acc <= 1'b0;
        par_bit <= 1'b0;
        fe_q    <= 1'b0;
      end else begin
        case (state)
          ST_DATA: begin
            if (bit_valid) begin
              shreg   <= {bit_in, shreg[DATA_W-1:1]};
              par_acc <= par_acc ^ bit_in;
              if (bit_cnt == DATA_LAST) begin
                bit_cnt <= '0;
                state   <= (mode_q == PAR_NONE) ? ST_STOP : ST_PARITY;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          ST_PARITY: begin
            if (bit_valid) begin
              par_bit <= bit_in;
              state   <= ST_STOP;
            end
          end
          ST_STOP: begin
            if (bit_valid) begin
              fe_q <= stop_fe;
              if (bit_cnt == STOP_LAST) begin
                state         <= ST_DONE;
                rx_valid      <= 1'b1;
                rx_data       <= shreg;
                framing_error <= stop_fe;
                parity_error  <= (mode_q != PAR_NONE) && (par_bit != par_exp);
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  uart_sat_counter #(.CNT_W(CNT_W)) u_parity_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pe_inc),
    .clr   (clear_cnt),
    .cnt   (parity_err_cnt)
  );

  uart_sat_counter #(.CNT_W(CNT_W)) u_framing_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (fe_inc),
    .clr   (clear_cnt),
    .cnt   (framing_err_cnt)
  );

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Self-checking bench for uart_rx_frame_check (DATA_W=8, STOP_BITS=2, CNT_W=2):
// directed frames with literal expectations, then randomized frames against a frame-level model.
module tb_uart_rx_frame_check;

  localparam int DW   = 8;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          frame_start;
  logic          bit_valid;
  logic          bit_in;
  logic [2:0]    parity_mode;
  logic          clear_cnt;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          parity_error;
  logic          framing_error;
  logic          busy;
  logic [CW-1:0] parity_err_cnt;
  logic [CW-1:0] framing_err_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Scoreboard: {fe, pe, data} per completed frame and the cycle it must appear.
  logic [DW+1:0] exp_q[$];
  int            due_q[$];
  logic [DW+1:0] hold;
  int            m_pcnt;
  int            m_fcnt;

  uart_rx_frame_check #(.DATA_W(DW), .STOP_BITS(2), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .frame_start     (frame_start),
    .bit_valid       (bit_valid),
    .bit_in          (bit_in),
    .parity_mode     (parity_mode),
    .clear_cnt       (clear_cnt),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .parity_error    (parity_error),
    .framing_error   (framing_error),
    .busy            (busy),
    .parity_err_cnt  (parity_err_cnt),
    .framing_err_cnt (framing_err_cnt)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc_drive(input logic fs, input logic bv, input logic bi);
    frame_start = fs;
    bit_valid   = bv;
    bit_in      = bi;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    bit_valid   = 1'b0;
    clear_cnt   = 1'b0;
  endtask

  // Idle cycles inside a frame: no strobes, but mode/bit_in/clear wander.
  task automatic idle_gap(input int n);
    for (int k = 0; k < n; k++) begin
      parity_mode = 3'($urandom_range(0, 7));
      clear_cnt   = ($urandom_range(0, 15) == 0);
      cyc_drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] data, input logic [2:0] mode,
                            input bit bad_par, input logic [1:0] stops,
                            input int abort_at, input bit fs_bv, input bit gaps);
    int   m;
    logic exp_par;
    logic pe;
    logic fe;
    m = (mode > 3'd4) ? 0 : int'(mode);
    case (m)
      1:       exp_par = ^data;
      2:       exp_par = ~^data;
      3:       exp_par = 1'b1;
      default: exp_par = 1'b0;
    endcase
    pe = (m != 0) && bad_par;
    fe = (stops != 2'b11);
    parity_mode = mode;
    cyc_drive(1'b1, fs_bv, 1'($urandom_range(0, 1)));
    for (int i = 0; i < DW; i++) begin
      if (i == abort_at) return;
      if (gaps) idle_gap($urandom_range(0, 2));
      cyc_drive(1'b0, 1'b1, data[i]);
    end
    if (m != 0) begin
      if (gaps) idle_gap($urandom_range(0, 2));
      cyc_drive(1'b0, 1'b1, exp_par ^ bad_par);
    end
    for (int s = 0; s < 2; s++) begin
      if (gaps) idle_gap($urandom_range(0, 2));
      if (s == 1) begin
        exp_q.push_back({fe, pe, data});
        due_q.push_back(cyc + 1);
      end
      cyc_drive(1'b0, 1'b1, stops[s]);
    end
  endtask

  task automatic chk_done(input string name, input logic [DW-1:0] d, input logic pe, input logic fe);
    chk({name, "_valid"}, 32'(rx_valid), 32'd1);
    chk({name, "_data"}, 32'(rx_data), 32'(d));
    chk({name, "_perr"}, 32'(parity_error), 32'(pe));
    chk({name, "_ferr"}, 32'(framing_error), 32'(fe));
  endtask

  // ---------------- scoreboard / compare process ----------------
  initial begin
    logic exp_v;
    hold   = '0;
    m_pcnt = 0;
    m_fcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        due_q.delete();
        hold   = '0;
        m_pcnt = 0;
        m_fcnt = 0;
        chk("reset_outputs",
            {16'd0, rx_valid, busy, parity_error, framing_error, rx_data, parity_err_cnt, framing_err_cnt},
            32'd0);
      end else begin
        if (due_q.size() > 0 && due_q[0] < cyc) begin
          chk("missed_rx_valid", 32'd0, 32'd1);
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
        end
        exp_v = (due_q.size() > 0) && (due_q[0] == cyc);
        chk("rx_valid", 32'(rx_valid), 32'(exp_v));
        if (exp_v) begin
          hold = exp_q.pop_front();
          void'(due_q.pop_front());
        end
        chk("rx_data", 32'(rx_data), 32'(hold[DW-1:0]));
        chk("parity_error", 32'(parity_error), 32'(hold[DW]));
        chk("framing_error", 32'(framing_error), 32'(hold[DW+1]));
        chk("parity_err_cnt", 32'(parity_err_cnt), 32'(m_pcnt));
        chk("framing_err_cnt", 32'(framing_err_cnt), 32'(m_fcnt));
        if (clear_cnt) begin
          m_pcnt = 0;
          m_fcnt = 0;
        end else if (exp_v) begin
          if (hold[DW] && m_pcnt < CMAX) m_pcnt++;
          if (hold[DW+1] && m_fcnt < CMAX) m_fcnt++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int lit[4];
    bit aborted;
    lit = '{1, 2, 3, 3};
    rst_n       = 1'b0;
    frame_start = 1'b0;
    bit_valid   = 1'b0;
    bit_in      = 1'b0;
    parity_mode = 3'd0;
    clear_cnt   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("post_reset_busy", 32'(busy), 32'd0);
    chk("post_reset_data", 32'(rx_data), 32'd0);

    // 1: even parity, 0x5A has even weight so parity bit 0 is correct
    send_frame(8'h5A, 3'd1, 1'b0, 2'b11, -1, 1'b0, 1'b0);
    chk_done("t1", 8'h5A, 1'b0, 1'b0);
    cyc_drive(1'b0, 1'b0, 1'b0);
    chk("t1_pcnt", 32'(parity_err_cnt), 32'd0);
    chk("t1_busy_after", 32'(busy), 32'd0);

    // 2: odd parity, 0x01 -> expected parity bit 0, so sending 1 is an error
    send_frame(8'h01, 3'd2, 1'b1, 2'b11, -1, 1'b0, 1'b0);
    chk_done("t2a", 8'h01, 1'b1, 1'b0);
    cyc_drive(1'b0, 1'b0, 1'b0);
    chk("t2a_pcnt", 32'(parity_err_cnt), 32'd1);
    send_frame(8'h01, 3'd2, 1'b0, 2'b11, -1, 1'b0, 1'b0);
    chk_done("t2b", 8'h01, 1'b0, 1'b0);

    // 3: no parity, second stop bit low
    send_frame(8'hFF, 3'd0, 1'b0, 2'b01, -1, 1'b0, 1'b0);
    chk_done("t3", 8'hFF, 1'b0, 1'b1);
    cyc_drive(1'b0, 1'b0, 1'b0);
    chk("t3_fcnt", 32'(framing_err_cnt), 32'd1);
    chk("t3_pcnt", 32'(parity_err_cnt), 32'd1);

    // 4: abort after three data bits with start+strobe together, then a clean frame
    send_frame(8'hA7, 3'd0, 1'b0, 2'b11, 3, 1'b0, 1'b0);
    chk("t4_busy_mid", 32'(busy), 32'd1);
    send_frame(8'h3C, 3'd0, 1'b0, 2'b11, -1, 1'b1, 1'b0);
    chk_done("t4", 8'h3C, 1'b0, 1'b0);

    // 5: counter saturation at CNT_W=2, then clear coinciding with an increment
    clear_cnt = 1'b1;
    cyc_drive(1'b0, 1'b0, 1'b0);
    chk("t5_cleared", 32'(parity_err_cnt), 32'd0);
    for (int k = 0; k < 4; k++) begin
      send_frame(8'($urandom_range(0, 255)), 3'd1, 1'b1, 2'b11, -1, 1'b0, 1'b0);
      cyc_drive(1'b0, 1'b0, 1'b0);
      chk("t5_pcnt", 32'(parity_err_cnt), 32'(lit[k]));
    end
    send_frame(8'h33, 3'd1, 1'b1, 2'b11, -1, 1'b0, 1'b0);
    clear_cnt = 1'b1;
    cyc_drive(1'b0, 1'b0, 1'b0);
    chk("t5_clear_wins", 32'(parity_err_cnt), 32'd0);

    // 6: mark / space, then reset in the middle of DATA
    send_frame(8'h96, 3'd3, 1'b1, 2'b11, -1, 1'b0, 1'b0);
    chk_done("t6_mark", 8'h96, 1'b1, 1'b0);
    send_frame(8'h96, 3'd4, 1'b0, 2'b11, -1, 1'b0, 1'b0);
    chk_done("t6_space", 8'h96, 1'b0, 1'b0);
    send_frame(8'hC3, 3'd1, 1'b0, 2'b11, 4, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_data", 32'(rx_data), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc_drive(1'b0, 1'b0, 1'b0);

    // Random frames: modes 0..7, bad parity/stop bits, gaps, aborts, back-to-back starts
    aborted = 1'b0;
    for (int f = 0; f < 200; f++) begin
      int   ab;
      int   gap_n;
      logic [1:0] stops;
      ab    = ($urandom_range(0, 7) == 0) ? $urandom_range(0, DW - 1) : -1;
      stops = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      send_frame(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0), stops, ab,
                 ($urandom_range(0, 3) == 0), 1'b1);
      aborted = (ab >= 0);
      gap_n = $urandom_range(0, 3);
      for (int k = 0; k < gap_n; k++) begin
        clear_cnt   = ($urandom_range(0, 7) == 0);
        parity_mode = 3'($urandom_range(0, 7));
        cyc_drive(1'b0, aborted ? 1'b0 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end
    repeat (4) cyc_drive(1'b0, 1'b0, 1'b0);
    chk("pending_frames", 32'(due_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
